// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects,
// memory-wait FSM state encoding and the hard-wired zero register index.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_unit_forward.sv
// Forwarding compare for one E-stage source operand; the M-stage ALU result
// is younger than the W result, so it wins when both match.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the 5-stage RV32 pipeline, with a
// data-memory wait tracker that latches a sticky timeout error.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [1:0]       state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;
  logic             mem_stall;
  logic             mem_pending;

  forward_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardAE)
  );

  forward_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (ForwardBE)
  );

  assign mem_pending = MemAccessM & ~MemReadyM;

  // E is frozen while memory stalls, so flushes are deferred until release.
  always_comb begin
    lw_stall  = ResultSrcE0 && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mem_stall = mem_pending || (state_q == ST_ERR);
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (!reset) begin
      StallF = lw_stall | mem_stall;
      StallD = lw_stall | mem_stall;
      StallE = mem_stall;
      StallM = mem_stall;
      FlushW = mem_stall;
      FlushD = PCSrcE & ~mem_stall;
      FlushE = (lw_stall | PCSrcE) & ~mem_stall;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (mem_pending) begin
          state_d    = ST_WAIT;
          wait_cnt_d = TO_W'(1);
        end
      end
      ST_WAIT: begin
        // A dropped access is treated as completed, same as a ready.
        if (MemReadyM || !MemAccessM) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_err_d   = mem_err_q | (state_q == ST_ERR);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: the stimulus process queues hand-computed
// expectations and a separate monitor pops and compares them each negedge.
module tb_hazard_unit;

  typedef struct {
    logic       reset;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       ld_e, pcsrc, rwm, rww, mem_acc, mem_rdy;
  } stim_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic [3:0] stall;
    logic [2:0] flush;
    logic       mem_err;
    logic [3:0] scnt, fcnt;
  } exp_t;

  localparam logic [3:0] ST_NONE = 4'b0000;
  localparam logic [3:0] ST_FD   = 4'b1100;
  localparam logic [3:0] ST_ALL  = 4'b1111;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_RST  = 3'b111;
  localparam logic [2:0] FL_DE   = 3'b110;
  localparam logic [2:0] FL_E    = 3'b010;
  localparam logic [2:0] FL_W    = 3'b001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
  logic [4:0] RdE = '0, RdM = '0, RdW = '0;
  logic       ResultSrcE0 = 1'b0, PCSrcE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic       MemAccessM = 1'b0, MemReadyM = 1'b0;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [3:0] StallCount, FlushCount;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clock = ~clock;

  hazard_unit #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 1'b0, rs1d: '0, rs2d: '0, rs1e: '0, rs2e: '0, rde: '0,
          rdm: '0, rdw: '0, ld_e: 1'b0, pcsrc: 1'b0, rwm: 1'b0, rww: 1'b0,
          mem_acc: 1'b0, mem_rdy: 1'b0};
    return s;
  endfunction

  function automatic exp_t mkExp(logic [1:0] fa, logic [1:0] fb, logic [3:0] st,
                                 logic [2:0] fl, logic me, int sc, int fc);
    exp_t e;
    e.fa = fa; e.fb = fb; e.stall = st; e.flush = fl; e.mem_err = me;
    e.scnt = 4'(sc); e.fcnt = 4'(fc);
    return e;
  endfunction

  task automatic applyStimulus(input string nm, input stim_t s, input exp_t e);
    @(posedge clock);
    #1;
    reset = s.reset; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; ResultSrcE0 = s.ld_e; PCSrcE = s.pcsrc;
    RegWriteM = s.rwm; RegWriteW = s.rww; MemAccessM = s.mem_acc; MemReadyM = s.mem_rdy;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cmpField(input string nm, input string fld, input logic [7:0] got,
                          input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %b expected %b", nm, fld, got, want);
    end
  endtask

  task automatic checkOutput(input string nm, input exp_t e);
    cmpField(nm, "fwd", {4'b0, ForwardAE, ForwardBE}, {4'b0, e.fa, e.fb});
    cmpField(nm, "stall", {4'b0, StallF, StallD, StallE, StallM}, {4'b0, e.stall});
    cmpField(nm, "flush", {5'b0, FlushD, FlushE, FlushW}, {5'b0, e.flush});
    cmpField(nm, "memerr", {7'b0, MemErr}, {7'b0, e.mem_err});
    cmpField(nm, "stallcnt", {4'b0, StallCount}, {4'b0, e.scnt});
    cmpField(nm, "flushcnt", {4'b0, FlushCount}, {4'b0, e.fcnt});
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checkOutput(nm, e);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stimulus
    stim_t s;
    s = idle(); s.reset = 1'b1;
    applyStimulus("reset_idle", s, mkExp(2'b00, 2'b00, ST_NONE, FL_RST, 0, 0, 0));
    s.rs1e = 5; s.rdm = 5; s.rwm = 1;
    applyStimulus("reset_fwd", s, mkExp(2'b10, 2'b00, ST_NONE, FL_RST, 0, 0, 0));

    s = idle(); s.rs1e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1;
    applyStimulus("fwd_m_over_w", s, mkExp(2'b10, 2'b00, ST_NONE, FL_NONE, 0, 0, 0));
    s.rdm = 0; s.rs2e = 5;
    applyStimulus("fwd_w_rdm0", s, mkExp(2'b01, 2'b01, ST_NONE, FL_NONE, 0, 0, 0));
    s.rdw = 0;
    applyStimulus("fwd_rf_x0", s, mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 0, 0));
    s = idle(); s.rs1e = 9; s.rs2e = 9; s.rdm = 9; s.rdw = 9; s.rww = 1;
    applyStimulus("fwd_m_disabled", s, mkExp(2'b01, 2'b01, ST_NONE, FL_NONE, 0, 0, 0));
    s = idle(); s.rs1e = 3; s.rs2e = 4; s.rdm = 4; s.rwm = 1; s.rdw = 3; s.rww = 1;
    applyStimulus("fwd_b_mem", s, mkExp(2'b01, 2'b10, ST_NONE, FL_NONE, 0, 0, 0));

    s = idle(); s.ld_e = 1; s.rde = 7; s.rs2d = 7;
    applyStimulus("lw_stall", s, mkExp(2'b00, 2'b00, ST_FD, FL_E, 0, 0, 0));
    applyStimulus("lw_released", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 1, 0));
    s = idle(); s.ld_e = 1;
    applyStimulus("lw_rd_x0", s, mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 1, 0));
    s = idle(); s.pcsrc = 1;
    applyStimulus("branch", s, mkExp(2'b00, 2'b00, ST_NONE, FL_DE, 0, 1, 0));
    applyStimulus("after_branch", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 1, 1));

    s = idle(); s.mem_acc = 1;
    applyStimulus("mem_wait1", s, mkExp(2'b00, 2'b00, ST_ALL, FL_W, 0, 1, 1));
    s.pcsrc = 1;
    applyStimulus("mem_wait2_br", s, mkExp(2'b00, 2'b00, ST_ALL, FL_W, 0, 2, 1));
    applyStimulus("mem_wait3_br", s, mkExp(2'b00, 2'b00, ST_ALL, FL_W, 0, 3, 1));
    s.mem_rdy = 1;
    applyStimulus("mem_release_br", s, mkExp(2'b00, 2'b00, ST_NONE, FL_DE, 0, 4, 1));
    applyStimulus("after_release", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 4, 2));

    s = idle(); s.ld_e = 1; s.rde = 7; s.rs1d = 7; s.pcsrc = 1;
    applyStimulus("lw_and_branch", s, mkExp(2'b00, 2'b00, ST_FD, FL_DE, 0, 4, 2));
    applyStimulus("after_lw_br", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 5, 3));

    // Five consecutive not-ready cycles with MEM_TIMEOUT=4 reach ERR.
    s = idle(); s.mem_acc = 1;
    for (int i = 0; i < 5; i++)
      applyStimulus($sformatf("timeout_%0d", i), s,
                    mkExp(2'b00, 2'b00, ST_ALL, FL_W, 0, 5 + i, 3));
    applyStimulus("err_entered", idle(), mkExp(2'b00, 2'b00, ST_ALL, FL_W, 0, 10, 3));
    s = idle(); s.pcsrc = 1;
    applyStimulus("err_sticky_br", s, mkExp(2'b00, 2'b00, ST_ALL, FL_W, 1, 11, 3));
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("err_hold_%0d", i), idle(),
                    mkExp(2'b00, 2'b00, ST_ALL, FL_W, 1, 12 + i, 3));
    applyStimulus("err_sat", idle(), mkExp(2'b00, 2'b00, ST_ALL, FL_W, 1, 15, 3));

    s = idle(); s.reset = 1;
    applyStimulus("reset_in_err", s, mkExp(2'b00, 2'b00, ST_NONE, FL_RST, 1, 15, 3));
    applyStimulus("reset_cleared", s, mkExp(2'b00, 2'b00, ST_NONE, FL_RST, 0, 0, 0));
    applyStimulus("post_reset_idle", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 0, 0));

    s = idle(); s.ld_e = 1; s.rde = 3; s.rs1d = 3;
    for (int i = 0; i < 20; i++)
      applyStimulus($sformatf("lw_sat_%0d", i), s,
                    mkExp(2'b00, 2'b00, ST_FD, FL_E, 0, (i > 15) ? 15 : i, 0));
    applyStimulus("lw_sat_hold", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 15, 0));

    // Dropping the access mid-wait must restart the timeout from scratch.
    s = idle(); s.mem_acc = 1;
    applyStimulus("drop_wait", s, mkExp(2'b00, 2'b00, ST_ALL, FL_W, 0, 15, 0));
    applyStimulus("drop_access", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 15, 0));
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("rearm_%0d", i), s,
                    mkExp(2'b00, 2'b00, ST_ALL, FL_W, 0, 15, 0));
    s.mem_rdy = 1;
    applyStimulus("rearm_ready", s, mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 15, 0));
    applyStimulus("rearm_idle", idle(), mkExp(2'b00, 2'b00, ST_NONE, FL_NONE, 0, 15, 0));

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32 core. It consumes the stage-tagged register indices and the E/M/W control bits issued by the controller.
- It returns the stall/flush controls, including FlushE, which the controller's ID/EX register consumes, and the E-stage operand forwarding selects.
- It adds a stateful data-memory wait tracker with a timeout, plus saturating performance counters.
- It sits beside the controller and datapath in the core top level.

Parameters:
MEM_TIMEOUT, 255, consecutive not-ready M-stage memory cycles before a fatal error (range 2..2^TO_W-1)
TO_W, 8, width of the wait counter
CNT_W, 32, width of each performance counter

Ports:
clock  in  1  core clock, rising edge
reset  in  1  synchronous, active-high
Rs1D, Rs2D  in  5  source registers in D
Rs1E, Rs2E  in  5  source registers in E
RdE, RdM, RdW  in  5  destination registers in E/M/W
ResultSrcE0  in  1  E-stage instruction is a load
PCSrcE  in  1  taken branch or jump resolved in E
RegWriteM, RegWriteW  in  1  register write enables in M/W
MemAccessM  in  1  load or store occupying M
MemReadyM  in  1  data memory completes the M access this cycle
ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 W result, 10 M ALU result
StallF, StallD, StallE, StallM  out  1  hold the stage register
FlushD, FlushE, FlushW  out  1  bubble the stage register
MemErr  out  1  sticky memory-timeout flag
StallCount, FlushCount  out  CNT_W  performance counters

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high; ports named clock and reset.
- Forwarding, per operand (combinational):
  - Select 10 if RegWriteM, RdM!=0 and RdM==Rs*E.
  - Otherwise select 01 if RegWriteW, RdW!=0 and RdW==Rs*E.
  - Otherwise select 00. M takes priority over W.
- lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- MemStall = (MemAccessM & ~MemReadyM) | (state==ERR).
- Stage controls:
  - StallF = StallD = lwStall | MemStall.
  - StallE = StallM = FlushW = MemStall. W receives a bubble while M is held.
  - FlushD = PCSrcE & ~MemStall.
  - FlushE = (lwStall | PCSrcE) & ~MemStall. E is frozen during MemStall, so no flush then. A redirect takes effect in the first cycle after release.
- Memory FSM, states IDLE, WAIT, ERR; wait_cnt is TO_W bits:
  - IDLE: if MemAccessM & ~MemReadyM, go to WAIT with wait_cnt=1; else stay, wait_cnt=0.
  - WAIT:
    - If MemReadyM, go to IDLE with wait_cnt=0.
    - Else if wait_cnt==MEM_TIMEOUT, go to ERR.
    - Else wait_cnt+1.
  - ERR: absorbing until reset; MemErr=1, pipeline fully stalled.
  - Effect: MEM_TIMEOUT+1 consecutive not-ready cycles give ERR on the next edge.
  - If MemAccessM drops while in WAIT, go to IDLE (treated as complete).
- Counters, no wrap: StallCount +1 each cycle StallF=1; FlushCount +1 each cycle FlushD=1. Both saturate at all-ones.
- Reset (while reset=1 and after): state=IDLE, wait_cnt=0, MemErr=0, counters=0. While reset is high, FlushD=FlushE=FlushW=1 and all Stall*=0; forwarding selects still follow the formula.
- Latency: all stall/flush/forward outputs are combinational, same cycle. MemErr is registered, asserting 1 cycle after the FSM enters ERR.
- Simultaneous lwStall+PCSrcE without MemStall: StallF/StallD=1, FlushD=1, FlushE=1. The branch wins on the D contents; the PC register holds and is redirected by the datapath's PCSrcE mux priority.

Decomposition:
- hazard_pkg: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; memory FSM state encoding; x0 index constant.
- Sub-module forward_unit: one operand's forwarding compare; instantiated twice (A, B).

Test Plan:
- Rs1E=5, RdM=5 RegWriteM=1, RdW=5 RegWriteW=1 -> ForwardAE=10. Same with RdM=0 -> ForwardAE=01. RdW=0 as well -> 00.
- ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1, FlushD=0 for exactly one cycle. RdE=0 -> no stall.
- PCSrcE=1 alone -> FlushD=FlushE=1, StallCount unchanged, FlushCount+1.
- MemAccessM=1, MemReadyM low 3 cycles then high -> StallF..StallM=FlushW=1 for 3 cycles. PCSrcE=1 during the wait -> FlushD/FlushE=0 until release, then 1.
- MEM_TIMEOUT=4, MemReadyM held low -> ERR entered after the 5th not-ready cycle. MemErr=1 next cycle and stays; stalls stay 1. Asserting reset clears MemErr and counters on the next edge.
- Preload counters near saturation (CNT_W=4 override), hold lwStall 20 cycles -> StallCount sticks at 15.
